// File: rtl/ysyx_24090012_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI4 read-channel arbiter.
// Covers the arbiter state encoding, owner encodings, AXI burst/resp codes,
// and a small helper used to detect the closing beat of a read burst.
// Optional feature macro: YSYX_ARB_RR_EN (round-robin tie breaking).
// The macro is consumed by the top-level file and is left undefined here.
package ysyx_24090012_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_AR    = 2'd1,
    ARB_R     = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // Requester indices: IFU is requester 0, LSU is requester 1.
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // True on the cycle the final beat of a burst is handed over.
  function automatic logic r_last_beat(input logic valid, input logic ready,
                                       input logic last);
    return valid & ready & last;
  endfunction

endpackage

// File: rtl/ysyx_24090012_arb_pick.sv
// Combinational 2-way grant picker for the read arbiter.
// A lone request always wins. When both requesters ask at once the one
// that was not granted last wins; tying rr_last low turns this into a
// fixed priority in favour of the LSU.
module ysyx_24090012_arb_pick
  import ysyx_24090012_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       grant_valid,
  output logic       grant
);

  // Pick the winner from the live request vector and the last grant.
  always_comb begin
    grant_valid = |req;
    grant       = OWNER_IFU;
    if (req == 2'b11) begin
      grant = ~rr_last;
    end else if (req[1]) begin
      grant = OWNER_LSU;
    end
  end

endmodule

// File: rtl/ysyx_24090012_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter (IFU = requester 0, LSU = 1).
// Grants one requester at a time, forwards its AR beat, routes R beats back
// until rlast, then returns to IDLE for re-arbitration. An IFU flush either
// drops a not-yet-accepted AR or drains the rest of an abandoned burst so the
// shared master port never stalls.
// Optional feature macro: YSYX_ARB_RR_EN. When defined, ties are broken
// round-robin using a registered last-grant bit; when undefined the LSU
// always wins ties and no last-grant state exists.
module ysyx_24090012_rd_arbiter
  import ysyx_24090012_rd_arbiter_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic           clock,
  input  logic           reset,

  input  logic           s0_arvalid,
  output logic           s0_arready,
  input  logic [AW-1:0]  s0_araddr,
  input  logic [IDW-1:0] s0_arid,
  input  logic [7:0]     s0_arlen,
  input  logic [2:0]     s0_arsize,
  input  logic [1:0]     s0_arburst,
  output logic           s0_rvalid,
  input  logic           s0_rready,
  output logic [DW-1:0]  s0_rdata,
  output logic [IDW-1:0] s0_rid,
  output logic [1:0]     s0_rresp,
  output logic           s0_rlast,
  input  logic           s0_flush,

  input  logic           s1_arvalid,
  output logic           s1_arready,
  input  logic [AW-1:0]  s1_araddr,
  input  logic [IDW-1:0] s1_arid,
  input  logic [7:0]     s1_arlen,
  input  logic [2:0]     s1_arsize,
  input  logic [1:0]     s1_arburst,
  output logic           s1_rvalid,
  input  logic           s1_rready,
  output logic [DW-1:0]  s1_rdata,
  output logic [IDW-1:0] s1_rid,
  output logic [1:0]     s1_rresp,
  output logic           s1_rlast,

  output logic           m_arvalid,
  input  logic           m_arready,
  output logic [AW-1:0]  m_araddr,
  output logic [IDW-1:0] m_arid,
  output logic [7:0]     m_arlen,
  output logic [2:0]     m_arsize,
  output logic [1:0]     m_arburst,

  input  logic           m_rvalid,
  output logic           m_rready,
  input  logic [DW-1:0]  m_rdata,
  input  logic [IDW-1:0] m_rid,
  input  logic [1:0]     m_rresp,
  input  logic           m_rlast,

  output logic           busy
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       owner_q;
  logic       owner_d;
  logic       pick_valid;
  logic       pick_grant;
  logic       rr_sel;
  logic       own_arvalid;
  logic       own_rready;
  logic       flush_hit;

  // The owner's handshake inputs; the other requester is invisible until re-arbitration.
  assign own_arvalid = (owner_q == OWNER_LSU) ? s1_arvalid : s0_arvalid;
  assign own_rready  = (owner_q == OWNER_LSU) ? s1_rready  : s0_rready;

  // Flush only matters while the IFU owns the port.
  assign flush_hit   = (owner_q == OWNER_IFU) && s0_flush;

  // AR fields follow the owner; requesters hold them stable while arvalid is high.
  assign m_araddr  = (owner_q == OWNER_LSU) ? s1_araddr  : s0_araddr;
  assign m_arid    = (owner_q == OWNER_LSU) ? s1_arid    : s0_arid;
  assign m_arlen   = (owner_q == OWNER_LSU) ? s1_arlen   : s0_arlen;
  assign m_arsize  = (owner_q == OWNER_LSU) ? s1_arsize  : s0_arsize;
  assign m_arburst = (owner_q == OWNER_LSU) ? s1_arburst : s0_arburst;

  // R payload is broadcast; only rvalid is steered to the owner.
  assign s0_rdata = m_rdata;
  assign s0_rid   = m_rid;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rdata = m_rdata;
  assign s1_rid   = m_rid;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  assign busy = (state_q != ARB_IDLE);

  ysyx_24090012_arb_pick u_pick (
    .req         ({s1_arvalid, s0_arvalid}),
    .rr_last     (rr_sel),
    .grant_valid (pick_valid),
    .grant       (pick_grant)
  );

`ifdef YSYX_ARB_RR_EN
  logic rr_last_q;
  logic txn_done;

  // A transaction ends on the owner's last beat or when a drain finishes;
  // a drained IFU burst still counts as the IFU's turn so the LSU cannot be starved by refetches.
  assign txn_done = ((state_q == ARB_R) && r_last_beat(m_rvalid, own_rready, m_rlast)) ||
                    ((state_q == ARB_DRAIN) && r_last_beat(m_rvalid, 1'b1, m_rlast));

  // Remember who was served last; reset favours the IFU on the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last_q <= OWNER_LSU;
    end else if (txn_done) begin
      rr_last_q <= owner_q;
    end
  end

  assign rr_sel = rr_last_q;
`else
  // Pretending the IFU always went last makes every tie go to the LSU.
  assign rr_sel = OWNER_IFU;
`endif

  // State and owner registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IFU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic and owner-steered handshake outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_grant;
          state_d = ARB_AR;
        end
      end

      ARB_AR: begin
        m_arvalid  = own_arvalid;
        s0_arready = (owner_q == OWNER_IFU) && m_arready;
        s1_arready = (owner_q == OWNER_LSU) && m_arready;
        if (own_arvalid && m_arready) begin
          state_d = flush_hit ? ARB_DRAIN : ARB_R;
        end else if (flush_hit) begin
          state_d = ARB_IDLE;
        end
      end

      ARB_R: begin
        m_rready  = own_rready;
        s0_rvalid = (owner_q == OWNER_IFU) && m_rvalid;
        s1_rvalid = (owner_q == OWNER_LSU) && m_rvalid;
        if (r_last_beat(m_rvalid, own_rready, m_rlast)) begin
          state_d = ARB_IDLE;
        end else if (flush_hit) begin
          state_d = ARB_DRAIN;
        end
      end

      ARB_DRAIN: begin
        m_rready = 1'b1;
        if (r_last_beat(m_rvalid, 1'b1, m_rlast)) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090012_rd_arbiter.sv
// Directed self-checking bench for ysyx_24090012_rd_arbiter.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// on the falling edge. Tie expectations follow YSYX_ARB_RR_EN.
module tb_ysyx_24090012_rd_arbiter;

  localparam logic [31:0] S0_ADDR = 32'h3000_0010;
  localparam logic [31:0] S1_ADDR = 32'h8000_0040;
  localparam logic [3:0]  S0_ID   = 4'h2;
  localparam logic [3:0]  S1_ID   = 4'h5;

`ifdef YSYX_ARB_RR_EN
  localparam bit TIE1_OWNER = 1'b0;
`else
  localparam bit TIE1_OWNER = 1'b1;
`endif

  logic        clock;
  logic        reset;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast, s0_flush;
  logic [31:0] s0_araddr, s0_rdata;
  logic [3:0]  s0_arid, s0_rid;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst, s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s1_araddr, s1_rdata;
  logic [3:0]  s1_arid, s1_rid;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst, s1_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, busy;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;

  int checks = 0;
  int errors = 0;

  ysyx_24090012_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arid(s0_arid), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rid(s0_rid),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_flush(s0_flush),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arid(s1_arid), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rid(s1_rid),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Move to the next stimulus slot, just after a rising edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
  endtask

  // Called in the slot where the DUT should be in AR for exp_owner: accept the
  // AR, then return beats read beats; ends in the slot after the last beat.
  task automatic grantAndServe(input string tag, input bit exp_owner, input int beats,
                               input int raise_s1_at);
    m_arready = 1'b1;
    @(negedge clock);
    checkOutput({tag, " m_arvalid"}, m_arvalid, 1);
    checkOutput({tag, " m_araddr"}, m_araddr, exp_owner ? S1_ADDR : S0_ADDR);
    checkOutput({tag, " m_arid"}, m_arid, exp_owner ? S1_ID : S0_ID);
    checkOutput({tag, " m_arlen"}, m_arlen, exp_owner ? s1_arlen : s0_arlen);
    checkOutput({tag, " s0_arready"}, s0_arready, !exp_owner);
    checkOutput({tag, " s1_arready"}, s1_arready, exp_owner);
    applyStimulus();
    m_arready = 1'b0;
    if (exp_owner) s1_arvalid = 1'b0;
    else s0_arvalid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      if (i == raise_s1_at) s1_arvalid = 1'b1;
      m_rvalid  = 1'b1;
      m_rlast   = (i == beats - 1);
      m_rdata   = 32'hA500_0000 + 32'(i);
      s0_rready = 1'b1;
      s1_rready = 1'b1;
      @(negedge clock);
      checkOutput({tag, " owner_rvalid"}, exp_owner ? s1_rvalid : s0_rvalid, 1);
      checkOutput({tag, " other_rvalid"}, exp_owner ? s0_rvalid : s1_rvalid, 0);
      checkOutput({tag, " owner_rdata"}, exp_owner ? s1_rdata : s0_rdata, 32'hA500_0000 + 32'(i));
      checkOutput({tag, " m_rready"}, m_rready, 1);
      checkOutput({tag, " s1_arready_in_r"}, s1_arready, 0);
      applyStimulus();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    s0_arvalid = 1'b0; s0_araddr = S0_ADDR; s0_arid = S0_ID; s0_arlen = 8'd3;
    s0_arsize = 3'd2; s0_arburst = 2'b01; s0_rready = 1'b0; s0_flush = 1'b0;
    s1_arvalid = 1'b0; s1_araddr = S1_ADDR; s1_arid = S1_ID; s1_arlen = 8'd0;
    s1_arsize = 3'd2; s1_arburst = 2'b01; s1_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = 4'h0; m_rresp = 2'b00;
    m_rlast = 1'b0;

    // Reset holds the arbiter idle even with requests pending.
    s0_arvalid = 1'b1;
    m_rvalid   = 1'b1;
    applyStimulus();
    applyStimulus();
    @(negedge clock);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst m_arvalid", m_arvalid, 0);
    checkOutput("rst m_rready", m_rready, 0);
    checkOutput("rst s0_arready", s0_arready, 0);
    checkOutput("rst s0_rvalid", s0_rvalid, 0);
    reset = 1'b1;
    s0_arvalid = 1'b0;
    m_rvalid   = 1'b0;
    applyStimulus();

    // IFU-only line fill with one-cycle grant latency.
    s0_arvalid = 1'b1;
    @(negedge clock);
    checkOutput("ifu latency m_arvalid", m_arvalid, 0);
    checkOutput("ifu latency busy", busy, 0);
    applyStimulus();
    grantAndServe("ifu", 1'b0, 4, -1);
    @(negedge clock);
    checkOutput("ifu done busy", busy, 0);
    applyStimulus();

    // Two ties right after reset, the first winner re-requesting for the second.
    pulseReset();
    s0_arvalid = 1'b1;
    s1_arvalid = 1'b1;
    @(negedge clock);
    checkOutput("tie1 busy", busy, 0);
    applyStimulus();
    grantAndServe("tie1", TIE1_OWNER, TIE1_OWNER ? 1 : 4, -1);
    if (TIE1_OWNER) s1_arvalid = 1'b1;
    else s0_arvalid = 1'b1;
    @(negedge clock);
    checkOutput("tie bubble busy", busy, 0);
    applyStimulus();
    grantAndServe("tie2", 1'b1, 1, -1);
    @(negedge clock);
    checkOutput("tie rest bubble", busy, 0);
    applyStimulus();
    grantAndServe("tie rest", 1'b0, 4, -1);

    // LSU request arriving at beat 2 of an IFU burst waits for re-arbitration.
    s0_arvalid = 1'b1;
    @(negedge clock);
    applyStimulus();
    grantAndServe("burst", 1'b0, 4, 1);
    @(negedge clock);
    checkOutput("lsu wait s1_arready", s1_arready, 0);
    checkOutput("lsu wait m_arvalid", m_arvalid, 0);
    checkOutput("lsu wait busy", busy, 0);
    applyStimulus();
    grantAndServe("lsu late", 1'b1, 1, -1);

    // Flush after the first beat drains the remaining three beats.
    s0_arvalid = 1'b1;
    @(negedge clock);
    applyStimulus();
    m_arready = 1'b1;
    @(negedge clock);
    checkOutput("flushR m_arvalid", m_arvalid, 1);
    applyStimulus();
    m_arready = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'h0BAD_0001; s0_rready = 1'b1;
    @(negedge clock);
    checkOutput("flushR beat1 s0_rvalid", s0_rvalid, 1);
    applyStimulus();
    m_rvalid = 1'b0; s0_flush = 1'b1;
    @(negedge clock);
    checkOutput("flushR busy", busy, 1);
    applyStimulus();
    s0_flush = 1'b0; s0_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1;
      m_rlast  = (i == 2);
      @(negedge clock);
      checkOutput("drain s0_rvalid", s0_rvalid, 0);
      checkOutput("drain m_rready", m_rready, 1);
      checkOutput("drain s1_arready", s1_arready, 0);
      checkOutput("drain busy", busy, 1);
      applyStimulus();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b1;
    @(negedge clock);
    checkOutput("drain done busy", busy, 0);
    applyStimulus();
    grantAndServe("after drain", 1'b1, 1, -1);

    // Flush while AR is still waiting drops the request.
    s0_arvalid = 1'b1;
    @(negedge clock);
    applyStimulus();
    m_arready = 1'b0; s0_flush = 1'b1;
    @(negedge clock);
    checkOutput("flushAR m_arvalid before", m_arvalid, 1);
    applyStimulus();
    s0_flush = 1'b0; s0_arvalid = 1'b0;
    @(negedge clock);
    checkOutput("flushAR m_arvalid after", m_arvalid, 0);
    checkOutput("flushAR busy", busy, 0);
    checkOutput("flushAR m_rready", m_rready, 0);
    applyStimulus();

    // Last beat and flush together: beat delivered, no drain.
    s0_arlen = 8'd0;
    s0_arvalid = 1'b1;
    @(negedge clock);
    applyStimulus();
    m_arready = 1'b1;
    @(negedge clock);
    checkOutput("lastflush m_arlen", m_arlen, 0);
    applyStimulus();
    m_arready = 1'b0; s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h1234_5678; s0_rready = 1'b1; s0_flush = 1'b1;
    @(negedge clock);
    checkOutput("lastflush s0_rvalid", s0_rvalid, 1);
    checkOutput("lastflush s0_rdata", s0_rdata, 32'h1234_5678);
    checkOutput("lastflush m_rready", m_rready, 1);
    applyStimulus();
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_flush = 1'b0;
    @(negedge clock);
    checkOutput("lastflush busy", busy, 0);
    applyStimulus();

    // LSU backpressure with an ignored flush, then reset mid-R.
    s1_arvalid = 1'b1;
    @(negedge clock);
    applyStimulus();
    m_arready = 1'b1;
    @(negedge clock);
    applyStimulus();
    m_arready = 1'b0; s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF; s1_rready = 1'b0; s0_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("bp m_rready", m_rready, 0);
      checkOutput("bp s1_rvalid", s1_rvalid, 1);
      checkOutput("bp s1_rdata", s1_rdata, 32'hDEAD_BEEF);
      checkOutput("bp busy", busy, 1);
      applyStimulus();
    end
    reset = 1'b0;
    @(negedge clock);
    checkOutput("sync rst pre-edge s1_rvalid", s1_rvalid, 1);
    applyStimulus();
    @(negedge clock);
    checkOutput("midR rst s1_rvalid", s1_rvalid, 0);
    checkOutput("midR rst s0_rvalid", s0_rvalid, 0);
    checkOutput("midR rst m_rready", m_rready, 0);
    checkOutput("midR rst m_arvalid", m_arvalid, 0);
    checkOutput("midR rst busy", busy, 0);
    reset = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; s0_flush = 1'b0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
